// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, FSM states and
// bit positions inside the {N,V,C,Z} flag word.
package alu_pkg;

    localparam int ALU_OPW = 3;

    localparam logic [ALU_OPW-1:0] OP_NOT = 3'b000;
    localparam logic [ALU_OPW-1:0] OP_ADD = 3'b001;
    localparam logic [ALU_OPW-1:0] OP_SUB = 3'b010;
    localparam logic [ALU_OPW-1:0] OP_SHL = 3'b011;
    localparam logic [ALU_OPW-1:0] OP_AND = 3'b100;
    localparam logic [ALU_OPW-1:0] OP_OR  = 3'b101;
    localparam logic [ALU_OPW-1:0] OP_XOR = 3'b110;
    localparam logic [ALU_OPW-1:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_shift_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles
// per product. The first bit is folded into the load so done pulses WIDTH-1
// edges after start.
module alu_shift_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;

    // NOTE: every register here uses <= so all of them see pre-edge values;
    // blocking assignments would let a later statement read an updated value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                acc_q    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
                mcand_q  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
                mplier_q <= b_i >> 1;
                cnt_q    <= CW'(WIDTH - 1);
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
// finish at the accept edge; multiply runs through the shift-add sub-block.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e             state_q;
    logic [WIDTH-1:0]   y_q;
    logic [3:0]         flags_q;

    logic [WIDTH-1:0]   res_d;
    logic [3:0]         flags_d;
    logic               c_d;
    logic               v_d;
    logic [WIDTH:0]     wide;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign in_ready  = (state_q == ST_IDLE) && !mul_busy;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (S == OP_MUL);

    alu_shift_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        wide  = '0;
        if (state_q == ST_MUL) begin
            res_d = mul_product[WIDTH-1:0];
            c_d   = |mul_product[2*WIDTH-1:WIDTH];
        end else begin
            case (S)
                OP_NOT: res_d = ~A;
                OP_ADD: begin
                    wide  = {1'b0, A} + {1'b0, B};
                    res_d = wide[WIDTH-1:0];
                    c_d   = wide[WIDTH];
                    v_d   = (A[WIDTH-1] == B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
                end
                OP_SUB: begin
                    wide  = {1'b0, A} - {1'b0, B};
                    res_d = wide[WIDTH-1:0];
                    c_d   = wide[WIDTH];
                    v_d   = (A[WIDTH-1] != B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
                end
                OP_SHL: begin
                    res_d = {A[WIDTH-2:0], 1'b0};
                    c_d   = A[WIDTH-1];
                    v_d   = A[WIDTH-1] ^ A[WIDTH-2];
                end
                OP_AND: res_d = A & B;
                OP_OR:  res_d = A | B;
                OP_XOR: res_d = A ^ B;
                OP_MUL: res_d = '0;
            endcase
        end
        flags_d         = '0;
        flags_d[FLAG_N] = res_d[WIDTH-1];
        flags_d[FLAG_V] = v_d;
        flags_d[FLAG_C] = c_d;
        flags_d[FLAG_Z] = (res_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (S == OP_MUL) begin
                            state_q <= ST_MUL;
                        end else begin
                            state_q <= ST_DONE;
                            y_q     <= res_d;
                            flags_q <= flags_d;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q <= ST_DONE;
                        y_q     <= res_d;
                        flags_q <= flags_d;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Y         = y_q;
    assign flags     = flags_q;
    assign out_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=8) with hand-computed results.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   S;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Y;
    logic [3:0]   flags;
    logic         out_valid;
    logic         out_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .S         (S),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, measure latency, optionally hold off the consumer,
    // then release it and confirm the block is back in IDLE.
    task automatic run_op(input string tag, input logic [2:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] y_exp,
                          input logic [3:0] f_exp, input int hold);
        int   lat;
        int   waitc;
        logic rdy_seen;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        check({tag, " ready_before"}, in_ready, 1);
        S = s; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; A = ~a; B = ~b; S = ~s;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            rdy_seen = rdy_seen | in_ready;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, (s == 3'b111) ? W + 1 : 1);
        if (s == 3'b111) check({tag, " ready_busy"}, rdy_seen, 0);
        check({tag, " Y"}, Y, y_exp);
        check({tag, " flags"}, flags, f_exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold_valid"}, out_valid, 1);
            check({tag, " hold_Y"}, Y, y_exp);
            check({tag, " hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle_valid"}, out_valid, 0);
        check({tag, " idle_ready"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        S = 3'b001; A = 8'h7F; B = 8'h01;
        #3;
        check("rst Y", Y, 0);
        check("rst flags", flags, 0);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        #9 rst = 1'b0;
        tick();
        in_valid = 1'b0;
        check("first_accept out_valid", out_valid, 1);
        check("add_ovf Y", Y, 8'h80);
        check("add_ovf flags", flags, 4'b1100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("add_ovf idle", in_ready, 1);

        run_op("sub_borrow", 3'b010, 8'h03, 8'h05, 8'hFE, 4'b1010, 0);
        run_op("sub_zero",   3'b010, 8'h05, 8'h05, 8'h00, 4'b0001, 0);
        run_op("sub_ovf",    3'b010, 8'h80, 8'h01, 8'h7F, 4'b0100, 0);
        run_op("add_carry",  3'b001, 8'hFF, 8'h01, 8'h00, 4'b0011, 0);
        run_op("mul_hi",     3'b111, 8'h10, 8'h11, 8'h10, 4'b0010, 0);
        run_op("not_bp",     3'b000, 8'hA5, 8'h00, 8'h5A, 4'b0000, 5);
        run_op("shl",        3'b011, 8'hC0, 8'h00, 8'h80, 4'b1010, 0);
        run_op("and",        3'b100, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0);
        run_op("or",         3'b101, 8'h0F, 8'h30, 8'h3F, 4'b0000, 0);
        run_op("xor",        3'b110, 8'hFF, 8'hFF, 8'h00, 4'b0001, 0);
        run_op("mul_lo",     3'b111, 8'h0F, 8'h0F, 8'hE1, 4'b1000, 0);

        S = 3'b111; A = 8'h10; B = 8'h11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        check("rst_mul Y", Y, 0);
        check("rst_mul flags", flags, 0);
        check("rst_mul out_valid", out_valid, 0);
        check("rst_mul in_ready", in_ready, 1);
        #1 rst = 1'b0;
        seen = 0;
        repeat (15) begin
            tick();
            seen = seen | int'(out_valid);
        end
        check("rst_mul no_stale", seen, 0);
        run_op("post_rst_add", 3'b001, 8'h12, 8'h34, 8'h46, 4'b0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
